// File: rtl/ysyx_25010008_axi_pkg.sv
// Shared AXI responder definitions: response codes and the responder FSM states.
package ysyx_25010008_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_DLY, S_RD_RSP, S_WR_COL, S_WR_DLY, S_WR_RSP
  } axi_state_e;
endpackage

// File: rtl/ysyx_25010008_sram_array.sv
// DEPTH x 32 word array, per-byte write enable, registered synchronous read port.
module ysyx_25010008_sram_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // contents deliberately survive reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ysyx_25010008_axi_sram.sv
// AXI4-lite memory responder: one transaction at a time, configurable R/W latency.
module ysyx_25010008_axi_sram
  import ysyx_25010008_axi_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 1024,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic        bvalid
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  function automatic logic hit(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  axi_state_e  state;
  logic [7:0]  cnt;
  logic [31:0] ar_q, aw_q, w_q;
  logic [3:0]  ws_q;
  logic        aw_got, w_got;

  assign arready = reset && (state == S_IDLE);
  assign awready = reset && ((state == S_IDLE && !arvalid) || (state == S_WR_COL && !aw_got));
  assign wready  = reset && ((state == S_IDLE && !arvalid) || (state == S_WR_COL && !w_got));

  // with zero latency the live channel values feed the array directly
  logic [31:0] rd_addr, wa, wd;
  logic [3:0]  wsel;
  assign rd_addr = (state == S_IDLE) ? araddr : ar_q;
  assign wa      = aw_got ? aw_q : awaddr;
  assign wd      = w_got  ? w_q  : wdata;
  assign wsel    = w_got  ? ws_q : wstrb;

  logic rd_go, wr_both, wr_go;
  assign rd_go   = (state == S_IDLE && arvalid && RD_LAT == 0) || (state == S_RD_DLY && cnt == 8'd1);
  assign wr_both = (state == S_IDLE && !arvalid && awvalid && wvalid) ||
                   (state == S_WR_COL && (aw_got || awvalid) && (w_got || wvalid));
  assign wr_go   = (wr_both && WR_LAT == 0) || (state == S_WR_DLY && cnt == 8'd1);

  logic [31:0] arr_q;
  ysyx_25010008_sram_array #(.DEPTH(DEPTH)) u_arr (
    .clock(clock), .reset(reset),
    .we(wr_go && hit(wa)), .waddr(idx(wa)), .wdata(wd), .wstrb(wsel),
    .re(rd_go && hit(rd_addr)), .raddr(idx(rd_addr)), .rdata(arr_q)
  );

  assign rdata = (rresp == RESP_SLVERR) ? 32'h0 : arr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE; cnt <= '0;
      ar_q <= '0; aw_q <= '0; w_q <= '0; ws_q <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
      rvalid <= 1'b0; bvalid <= 1'b0; rresp <= RESP_OKAY; bresp <= RESP_OKAY;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid) begin
            ar_q <= araddr;
            if (rd_go) begin
              state <= S_RD_RSP; rvalid <= 1'b1;
              rresp <= hit(araddr) ? RESP_OKAY : RESP_SLVERR;
            end else begin
              state <= S_RD_DLY; cnt <= 8'(RD_LAT);
            end
          end else if (awvalid || wvalid) begin
            if (awvalid) begin aw_q <= awaddr; aw_got <= 1'b1; end
            if (wvalid)  begin w_q <= wdata; ws_q <= wstrb; w_got <= 1'b1; end
            if (wr_go) begin
              state <= S_WR_RSP; bvalid <= 1'b1;
              bresp <= hit(wa) ? RESP_OKAY : RESP_SLVERR;
            end else if (wr_both) begin
              state <= S_WR_DLY; cnt <= 8'(WR_LAT);
            end else state <= S_WR_COL;
          end
        end
        S_WR_COL: begin
          if (awvalid && !aw_got) begin aw_q <= awaddr; aw_got <= 1'b1; end
          if (wvalid && !w_got) begin w_q <= wdata; ws_q <= wstrb; w_got <= 1'b1; end
          if (wr_go) begin
            state <= S_WR_RSP; bvalid <= 1'b1;
            bresp <= hit(wa) ? RESP_OKAY : RESP_SLVERR;
          end else if (wr_both) begin
            state <= S_WR_DLY; cnt <= 8'(WR_LAT);
          end
        end
        S_RD_DLY: begin
          cnt <= cnt - 8'd1;
          if (rd_go) begin
            state <= S_RD_RSP; rvalid <= 1'b1;
            rresp <= hit(ar_q) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        S_WR_DLY: begin
          cnt <= cnt - 8'd1;
          if (wr_go) begin
            state <= S_WR_RSP; bvalid <= 1'b1;
            bresp <= hit(aw_q) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        S_RD_RSP: if (rready) begin rvalid <= 1'b0; state <= S_IDLE; end
        S_WR_RSP: if (bready) begin
          bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
